range_sorter: RTL and testbench
===============================

RANGE_SORTER -- requirements
Module: range_sorter

Interface
REQ-001 SHALL expose parameter N, default 50, width of range start and end values.
REQ-002 SHALL expose parameter DEPTH, default 186, maximum ranges held per batch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream range present.
REQ-006 SHALL have port in_ready  output  1  block accepts range this cycle.
REQ-007 SHALL have port in_start  input  N  range start (inclusive).
REQ-008 SHALL have port in_end  input  N  range end (inclusive).
REQ-009 SHALL have port in_last  input  1  marks final range of batch; qualified by in_valid.
REQ-010 SHALL have port out_valid  output  1  sorted range present.
REQ-011 SHALL have port out_ready  input  1  downstream (merge/count stage) accepts range.
REQ-012 SHALL have port out_start  output  N  sorted range start.
REQ-013 SHALL have port out_end  output  N  sorted range end.
REQ-014 SHALL have port out_last  output  1  marks final sorted range of batch.
REQ-015 SHALL have port range_count  output  $clog2(DEPTH+1)  ranges currently stored.
REQ-016 SHALL have port overflow  output  1  sticky: batch truncated at DEPTH.
REQ-017 SHALL have port dropped  output  1  sticky: a range with start > end was discarded.

Function
REQ-018 SHALL implement FSM states LOAD and DRAIN; reset state LOAD.
REQ-019 Transfer SHALL occur only when valid and ready are both high on the same edge (input and output sides independently).
REQ-020 LOAD: in_ready SHALL be 1 while range_count < DEPTH; out_valid SHALL be 0.
REQ-021 LOAD: each accepted range SHALL be inserted in one cycle into a shift-register array, kept in ascending order by start, ties by end.
REQ-022 Equal (start,end) keys SHALL keep arrival order (stable insertion).
REQ-023 Accepted range with in_start > in_end SHALL NOT be stored; dropped SHALL set to 1; in_last on it still ends the batch.
REQ-024 Accepting in_last SHALL move FSM to DRAIN on the next edge.
REQ-025 range_count reaching DEPTH without in_last SHALL move FSM to DRAIN and set overflow to 1 on the same edge.
REQ-026 in_last accepted on the range that makes range_count = DEPTH SHALL NOT set overflow.
REQ-027 Batch ending with range_count = 0 (all dropped) SHALL return to LOAD without asserting out_valid.
REQ-028 DRAIN: in_ready SHALL be 0; out_valid SHALL be 1; out_start/out_end SHALL present entry at read index, starting at index 0 (smallest).
REQ-029 First out_valid SHALL occur on the cycle after the edge that accepted the batch-ending range (latency 1).
REQ-030 Read index SHALL advance by 1 per accepted output; outputs SHALL hold stable while out_valid high and out_ready low.
REQ-031 out_last SHALL be 1 exactly when read index = range_count-1.
REQ-032 Accepting the out_last transfer SHALL clear range_count and read index and return FSM to LOAD on the same edge; in_ready 1 on the following cycle.
REQ-033 Comparisons SHALL be unsigned over full N bits; no arithmetic widening or wrap.
REQ-034 overflow and dropped SHALL clear only on reset.

Reset
REQ-035 reset SHALL override all other activity on any edge, including mid-LOAD and mid-DRAIN, discarding stored ranges.
REQ-036 After reset: state LOAD, in_ready=1, out_valid=0, out_last=0, out_start=0, out_end=0, range_count=0, overflow=0, dropped=0.
REQ-037 Storage array contents need not be cleared; they SHALL never reach outputs unless rewritten.

Verification
REQ-038 Load (10,14),(3,5),(16,20),(12,18) last on 4th, out_ready=1 -> out (3,5),(10,14),(12,18),(16,20), out_last on 4th, first out_valid 1 cycle after last accept.
REQ-039 Load (7,9),(7,8),(7,9) -> out (7,8),(7,9),(7,9); out_ready toggled 1/0 -> data held stable during stalls, no duplicates or skips.
REQ-040 DEPTH=4, load 5 ranges without in_last -> 4 sorted ranges drained, overflow=1, 5th accepted only after return to LOAD.
REQ-041 Load (9,2) with in_last -> dropped=1, out_valid never asserted, in_ready=1 on the next cycle.
REQ-042 Assert reset during DRAIN after 2 of 4 outputs -> next cycle all outputs at reset values; a new 1-range batch (5,5) drains as (5,5) with out_last=1.
REQ-043 Load N-bit extremes (2^50-1,2^50-1),(0,0) -> out (0,0) then (2^50-1,2^50-1).

Source files
------------

// File: rtl/range_sorter_if.sv
// range_sorter_if: streaming handshake bundle for range_sorter.
//   Input side : in_valid/in_ready handshake carrying in_start, in_end, in_last.
//   Output side: out_valid/out_ready handshake carrying out_start, out_end, out_last.
//   master modport: the environment (drives in_* payload and out_ready).
//   slave  modport: the sorter (drives in_ready and out_* payload).
interface range_sorter_if #(
    parameter int N = 50
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_start;
    logic [N-1:0] in_end;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_start;
    logic [N-1:0] out_end;
    logic         out_last;

    modport master (
        output in_valid, in_start, in_end, in_last, out_ready,
        input  in_ready, out_valid, out_start, out_end, out_last
    );

    modport slave (
        input  in_valid, in_start, in_end, in_last, out_ready,
        output in_ready, out_valid, out_start, out_end, out_last
    );
endinterface

// File: rtl/range_sorter.sv
// range_sorter: collects a batch of [start,end] ranges, keeps them sorted
// ascending by (start, end) in a shift-register array as they arrive, then
// streams them out smallest first.
//   clk, reset  : single clock, synchronous active-high reset.
//   bus         : range_sorter_if slave (input and output handshakes).
//   range_count : number of ranges currently stored.
//   overflow    : sticky, batch was cut short at DEPTH entries.
//   dropped     : sticky, a range with start > end was discarded.
module range_sorter #(
    parameter int N     = 50,
    parameter int DEPTH = 186
) (
    input  logic                       clk,
    input  logic                       reset,
    range_sorter_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] range_count,
    output logic                       overflow,
    output logic                       dropped
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t        state;
    logic [N-1:0]  st_s [DEPTH];
    logic [N-1:0]  st_e [DEPTH];
    logic [IW-1:0] rd_idx;
    logic [DEPTH-1:0] keep;
    logic          in_fire;
    logic          out_fire;
    logic          ins;
    logic          bad;
    logic [CW-1:0] count_nxt;

    assign bus.in_ready  = (state == LOAD) && (range_count < CW'(DEPTH));
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_last  = (state == DRAIN) && (CW'(rd_idx) == range_count - 1'b1);
    assign bus.out_start = (state == DRAIN) ? st_s[rd_idx] : '0;
    assign bus.out_end   = (state == DRAIN) ? st_e[rd_idx] : '0;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign ins       = in_fire && (bus.in_start <= bus.in_end);
    assign bad       = in_fire && (bus.in_start > bus.in_end);
    assign count_nxt = range_count + CW'(ins);

    // keep[i]: occupied slot i sorts at or before the incoming range, so it
    // stays put. Using <= on the end key puts equal keys after existing
    // ones, which preserves arrival order.
    always_comb begin
        keep = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            keep[IW'(i)] = (CW'(i) < range_count) &&
                           ((st_s[IW'(i)] < bus.in_start) ||
                            ((st_s[IW'(i)] == bus.in_start) && (st_e[IW'(i)] <= bus.in_end)));
        end
    end

    // Kept slots form a prefix; the first non-kept slot takes the new range
    // and every later slot takes its lower neighbour.
    always_ff @(posedge clk) begin
        if (ins) begin
            if (!keep[0]) begin
                st_s[0] <= bus.in_start;
                st_e[0] <= bus.in_end;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (!keep[IW'(i)]) begin
                    if (keep[IW'(i - 1)]) begin
                        st_s[IW'(i)] <= bus.in_start;
                        st_e[IW'(i)] <= bus.in_end;
                    end else begin
                        st_s[IW'(i)] <= st_s[IW'(i - 1)];
                        st_e[IW'(i)] <= st_e[IW'(i - 1)];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            range_count <= '0;
            rd_idx      <= '0;
            overflow    <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        range_count <= count_nxt;
                        if (bad) dropped <= 1'b1;
                        if (bus.in_last) begin
                            // An all-dropped batch has nothing to drain.
                            if (count_nxt != '0) state <= DRAIN;
                        end else if (count_nxt == CW'(DEPTH)) begin
                            state    <= DRAIN;
                            overflow <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (bus.out_last) begin
                            state       <= LOAD;
                            range_count <= '0;
                            rd_idx      <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_range_sorter.sv
// tb_range_sorter: directed and randomized checks of range_sorter against a
// queue-based reference model (collect batch, sort it, hand it out in order).
module tb_range_sorter;
    localparam int N  = 50;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    typedef logic [2*N-1:0] key_t;
    typedef logic [2*N:0]   cap_t;

    logic          clk;
    logic          reset;
    logic [CW-1:0] range_count;
    logic          overflow;
    logic          dropped;

    range_sorter_if #(.N(N)) bus ();

    range_sorter #(.N(N), .DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .range_count (range_count),
        .overflow    (overflow),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;
    int   rmode   = 3;
    cap_t cap_q[$];

    // Reference model state.
    key_t m_q[$];
    int   m_rd    = 0;
    bit   m_drain = 0;
    bit   m_ovf   = 0;
    bit   m_drop  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready pattern: 0 always, 1 toggle, 2 random, 3 held low.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ~bus.out_ready;
            2: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Model: a batch is just the list of accepted well-formed ranges; once
    // the batch closes it is sorted by (start,end) and read out in order.
    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_rd    = 0;
            m_drain = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else if (!m_drain) begin
            if (bus.in_valid === 1'b1 && m_q.size() < D) begin
                if (bus.in_start > bus.in_end) m_drop = 1;
                else m_q.push_back({bus.in_start, bus.in_end});
                if (bus.in_last) begin
                    if (m_q.size() > 0) begin
                        m_q.sort();
                        m_drain = 1;
                    end
                end else if (m_q.size() == D) begin
                    m_q.sort();
                    m_drain = 1;
                    m_ovf   = 1;
                end
            end
        end else if (bus.out_ready === 1'b1) begin
            if (m_rd == m_q.size() - 1) begin
                m_q.delete();
                m_rd    = 0;
                m_drain = 0;
            end else begin
                m_rd++;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, !m_drain && m_q.size() < D);
            chk("out_valid", bus.out_valid, m_drain);
            chk("range_count", range_count, m_q.size());
            chk("overflow", overflow, m_ovf);
            chk("dropped", dropped, m_drop);
            if (m_drain) begin
                chk("out_start", bus.out_start, m_q[m_rd][2*N-1:N]);
                chk("out_end", bus.out_end, m_q[m_rd][N-1:0]);
                chk("out_last", bus.out_last, m_rd == m_q.size() - 1);
            end else begin
                chk("out_last_idle", bus.out_last, 0);
            end
            if (bus.out_valid && bus.out_ready)
                cap_q.push_back({bus.out_last, bus.out_start, bus.out_end});
        end
    end

    task automatic send(input logic [N-1:0] s, input logic [N-1:0] e, input logic l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_start = s;
        bus.in_end   = e;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("send_timeout", t, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_caps(input int k);
        int t = 0;
        while (cap_q.size() < k && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("cap_count", cap_q.size(), k);
    endtask

    task automatic expect_out(input string name, input int idx,
                              input logic [N-1:0] s, input logic [N-1:0] e, input logic l);
        chk({name, "_present"}, cap_q.size() > idx, 1);
        if (cap_q.size() > idx) chk(name, cap_q[idx], {l, s, e});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[N-1:0];
    endfunction

    initial begin
        logic [N-1:0] mx;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] tmp;
        mx = '1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_start = '0;
        bus.in_end   = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1;

        // Reset state.
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_start", bus.out_start, 0);
        chk("rst_out_end", bus.out_end, 0);
        chk("rst_count", range_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropped", dropped, 0);

        // Basic sort, first output one cycle after last accept.
        rmode = 0;
        cap_q.delete();
        send(10, 14, 0);
        send(3, 5, 0);
        send(16, 20, 0);
        send(12, 18, 1);
        chk("lat_out_valid", bus.out_valid, 1);
        chk("lat_out_start", bus.out_start, 3);
        wait_caps(4);
        expect_out("b1_0", 0, 3, 5, 0);
        expect_out("b1_1", 1, 10, 14, 0);
        expect_out("b1_2", 2, 12, 18, 0);
        expect_out("b1_3", 3, 16, 20, 1);
        chk("b1_no_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #1;

        // Ties with stalling consumer.
        rmode = 1;
        cap_q.delete();
        send(7, 9, 0);
        send(7, 8, 0);
        send(7, 9, 1);
        wait_caps(3);
        expect_out("tie_0", 0, 7, 8, 0);
        expect_out("tie_1", 1, 7, 9, 0);
        expect_out("tie_2", 2, 7, 9, 1);
        repeat (3) @(posedge clk);
        #1;

        // Lone malformed range ends the batch with nothing to drain.
        rmode = 0;
        cap_q.delete();
        send(9, 2, 1);
        chk("drop_flag", dropped, 1);
        chk("drop_in_ready", bus.in_ready, 1);
        chk("drop_out_valid", bus.out_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("drop_no_output", cap_q.size(), 0);

        // Overflow: fifth range waits for the next LOAD.
        cap_q.delete();
        send(8, 9, 0);
        send(2, 3, 0);
        send(6, 6, 0);
        send(1, 9, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_out_valid", bus.out_valid, 1);
        chk("ovf_in_ready", bus.in_ready, 0);
        send(5, 5, 0);
        chk("ovf_fifth_count", range_count, 1);
        wait_caps(4);
        expect_out("ovf_0", 0, 1, 9, 0);
        expect_out("ovf_1", 1, 2, 3, 0);
        expect_out("ovf_2", 2, 6, 6, 0);
        expect_out("ovf_3", 3, 8, 9, 1);
        send(11, 12, 1);
        wait_caps(6);
        expect_out("ovf_4", 4, 5, 5, 0);
        expect_out("ovf_5", 5, 11, 12, 1);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a drain.
        rmode = 1;
        cap_q.delete();
        send(4, 4, 0);
        send(3, 3, 0);
        send(2, 2, 0);
        send(1, 1, 1);
        wait_caps(2);
        chk("mid_drain", bus.out_valid, 1);
        do_reset();
        chk("mr_in_ready", bus.in_ready, 1);
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_out_last", bus.out_last, 0);
        chk("mr_out_start", bus.out_start, 0);
        chk("mr_out_end", bus.out_end, 0);
        chk("mr_count", range_count, 0);
        chk("mr_overflow", overflow, 0);
        chk("mr_dropped", dropped, 0);
        rmode = 0;
        cap_q.delete();
        send(5, 5, 1);
        wait_caps(1);
        expect_out("mr_single", 0, 5, 5, 1);
        repeat (2) @(posedge clk);
        #1;

        // Full-width extremes.
        cap_q.delete();
        send(mx, mx, 0);
        send(0, 0, 1);
        wait_caps(2);
        expect_out("ext_0", 0, 0, 0, 0);
        expect_out("ext_1", 1, mx, mx, 1);
        repeat (2) @(posedge clk);
        #1;

        // Randomized batches checked by the model.
        rmode = 2;
        for (int bi = 0; bi < 60; bi++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 2) == 0) begin
                    a = N'($urandom_range(0, 3));
                    b = N'($urandom_range(0, 3));
                end else begin
                    a = rnd();
                    b = rnd();
                end
                if (a > b) begin
                    tmp = a;
                    a   = b;
                    b   = tmp;
                end
                if ($urandom_range(0, 5) == 0) begin
                    tmp = a;
                    a   = b;
                    b   = tmp;
                end
                send(a, b, (j == len - 1) && ($urandom_range(0, 4) != 0));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        begin
            int t = 0;
            while (m_drain && t < 300) begin
                @(posedge clk);
                t++;
            end
            #1;
            chk("final_idle", m_drain, 0);
        end
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
